o_tx_uart_framer: RTL and testbench

Downstream serializer for the stepper controller's 40-bit signed timing output (`o_tx`). It latches one 40-bit word on request and transmits it as a framed, checksummed 8N1 UART packet on a single TX pin for host-side logging. It runs in the 50 MHz domain beside the stepper controller and needs no clock crossing.

---
 rtl/o_tx_uart_framer.sv | 165 ++++++++++++++++
 tb/tb_o_tx_uart_framer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/o_tx_uart_framer.sv
// Purpose : frames one latched 40-bit word as a 7-byte 8N1 UART packet (sync, 5 data bytes MSB first, XOR checksum).
// Latency : i_Data latched on the acceptance edge; start bit on the line from the next edge; o_Done 70*CLKS_PER_BIT+1 cycles after acceptance.
// Backpressure: i_Send is a level request, accepted only while the framer is idle; requests during a frame are dropped, never queued.
//
// Ports:
//   i_clk_50   50 MHz system clock, all logic on its rising edge
//   i_rst_n    asynchronous active-low reset
//   i_Data     40-bit word to transmit, sampled only on acceptance
//   i_Send     level-sensitive send request
//   o_Busy     high while a frame is in flight
//   o_Done     one-cycle pulse when a frame completes
//   o_Uart_Tx  registered serial line, idle high

module o_tx_uart_framer #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic        i_clk_50,
   input  logic        i_rst_n,
   input  logic [39:0] i_Data,
   input  logic        i_Send,
   output logic        o_Busy,
   output logic        o_Done,
   output logic        o_Uart_Tx
);

   localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BYTE = 3'd6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       byte_idx;
   logic [39:0]      hold_q;
   logic             frame_end_q;

   logic [7:0]       chk_byte;
   logic [7:0]       cur_byte;
   logic             bit_end;
   logic             tx_nxt;

   // Checksum is derived from the holding register, so it can never disagree
   // with the data bytes actually sent, whatever i_Data does mid-frame.
   assign chk_byte = hold_q[39:32] ^ hold_q[31:24] ^ hold_q[23:16]
                   ^ hold_q[15:8]  ^ hold_q[7:0];

   assign bit_end = (clk_cnt == CNT_MAX);

   always_comb begin
      cur_byte = SYNC_BYTE;
      case (byte_idx)
         3'd0:    cur_byte = SYNC_BYTE;
         3'd1:    cur_byte = hold_q[39:32];
         3'd2:    cur_byte = hold_q[31:24];
         3'd3:    cur_byte = hold_q[23:16];
         3'd4:    cur_byte = hold_q[15:8];
         3'd5:    cur_byte = hold_q[7:0];
         3'd6:    cur_byte = chk_byte;
         default: cur_byte = SYNC_BYTE;
      endcase
   end

   // Line level for the bit the FSM is currently in; registered below so the
   // pin never sees decode glitches.
   always_comb begin
      tx_nxt = 1'b1;
      case (state)
         ST_IDLE:  tx_nxt = 1'b1;
         ST_START: tx_nxt = 1'b0;
         ST_DATA:  tx_nxt = cur_byte[bit_idx];
         ST_STOP:  tx_nxt = 1'b1;
         default:  tx_nxt = 1'b1;
      endcase
   end

   // Frame sequencer. The FSM returns to IDLE on the last edge of the final
   // stop bit, so a held request is accepted on the very next edge and the
   // line shows exactly one idle-high cycle between frames.
   always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         byte_idx    <= '0;
         hold_q      <= '0;
         frame_end_q <= 1'b0;
      end else begin
         frame_end_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               clk_cnt <= '0;
               if (i_Send) begin
                  hold_q   <= i_Data;
                  bit_idx  <= '0;
                  byte_idx <= '0;
                  state    <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  state   <= ST_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  // 3-bit index wraps 7->0, leaving it ready for the next byte.
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            ST_STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (byte_idx == LAST_BYTE) begin
                     state       <= ST_IDLE;
                     frame_end_q <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= ST_START;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output stage: one register behind the FSM. This is what places the start
   // bit one edge after acceptance and lines o_Done / the falling o_Busy up
   // with the first idle-high cycle after the last stop bit.
   always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_Uart_Tx <= 1'b1;
         o_Busy    <= 1'b0;
         o_Done    <= 1'b0;
      end else begin
         o_Uart_Tx <= tx_nxt;
         o_Busy    <= (state != ST_IDLE);
         o_Done    <= frame_end_q;
      end
   end

endmodule

// File: tb/tb_o_tx_uart_framer.sv
module tb_o_tx_uart_framer;

   logic        i_clk_50 = 1'b0;
   logic        i_rst_n;
   logic [39:0] i_Data;
   logic        i_Send;
   logic        o_Busy;
   logic        o_Done;
   logic        o_Uart_Tx;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0;
   logic saw_busy;

   o_tx_uart_framer #(
      .CLKS_PER_BIT (4),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .i_clk_50  (i_clk_50),
      .i_rst_n   (i_rst_n),
      .i_Data    (i_Data),
      .i_Send    (i_Send),
      .o_Busy    (o_Busy),
      .o_Done    (o_Done),
      .o_Uart_Tx (o_Uart_Tx)
   );

   always #5 i_clk_50 = ~i_clk_50;

   always @(negedge i_clk_50) begin
      if (o_Done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic tick();
      @(posedge i_clk_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called one tick after the acceptance edge. Samples every cycle of the
   // 280-cycle frame; returns one tick before o_Done is due.
   task automatic rx_frame(input string tag, input logic [55:0] exp_bytes,
                           input int poke_a, input int poke_b,
                           input int chg_at, input logic [39:0] chg_val,
                           input logic hold);
      logic [55:0] got;
      logic [9:0]  sh;
      logic        fmt_ok, busy_ok, no_done;
      int          lead, bi, c;
      got = '0; sh = '0; fmt_ok = 1'b1; busy_ok = 1'b1; no_done = 1'b1;
      lead = 0;
      while (o_Uart_Tx !== 1'b0 && lead < 50) begin
         tick();
         lead++;
      end
      for (int k = 0; k < 280; k++) begin
         if (k > 0) tick();
         if (!hold) i_Send = (k == poke_a) || (k == poke_b);
         if (k == chg_at) i_Data = chg_val;
         bi = (k / 4) % 10;
         c  = k % 4;
         if (c == 0) sh[bi] = o_Uart_Tx;
         else if (o_Uart_Tx !== sh[bi]) fmt_ok = 1'b0;
         if (o_Busy !== 1'b1) busy_ok = 1'b0;
         if (o_Done !== 1'b0) no_done = 1'b0;
         if (k % 40 == 39) begin
            if (sh[0] !== 1'b0 || sh[9] !== 1'b1) fmt_ok = 1'b0;
            got = {got[47:0], sh[8:1]};
         end
      end
      chk({tag, "_lead"},    64'(lead), 64'd1);
      chk({tag, "_bytes"},   64'(got), 64'(exp_bytes));
      chk({tag, "_format"},  64'(fmt_ok), 64'd1);
      chk({tag, "_busy"},    64'(busy_ok), 64'd1);
      chk({tag, "_nodone"},  64'(no_done), 64'd1);
   endtask

   task automatic frame_end(input string tag);
      tick();
      chk({tag, "_done"},    64'(o_Done), 64'd1);
      chk({tag, "_busy_lo"}, 64'(o_Busy), 64'd0);
      chk({tag, "_tx_hi"},   64'(o_Uart_Tx), 64'd1);
   endtask

   initial begin
      i_rst_n = 1'b1;
      i_Send  = 1'b0;
      i_Data  = '0;

      // Asynchronous reset between edges, with a request pending.
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("rst_tx",   64'(o_Uart_Tx), 64'd1);
      chk("rst_busy", 64'(o_Busy),    64'd0);
      chk("rst_done", 64'(o_Done),    64'd0);
      i_Send = 1'b1;
      i_Data = 40'h11_1111_1111;
      repeat (3) tick();
      chk("rst_hold_busy", 64'(o_Busy),    64'd0);
      chk("rst_hold_tx",   64'(o_Uart_Tx), 64'd1);
      i_Send  = 1'b0;
      i_rst_n = 1'b1;
      repeat (2) tick();
      chk("post_rst_busy", 64'(o_Busy),    64'd0);
      chk("post_rst_tx",   64'(o_Uart_Tx), 64'd1);

      // Nominal frame, 100000 = 0x00_0001_86A0, checksum 0x27.
      d0 = done_cnt;
      i_Data = 40'd100000;
      i_Send = 1'b1;
      tick();
      i_Send = 1'b0;
      rx_frame("nom", 56'hA5_00_00_01_86_A0_27, -1, -1, -1, '0, 1'b0);
      frame_end("nom");
      tick();
      chk("nom_done_low", 64'(o_Done), 64'd0);
      chk("nom_done_cnt", 64'(done_cnt - d0), 64'd1);

      // All-ones word; i_Data cleared mid-frame must not matter.
      i_Data = 40'hFF_FFFF_FFFF;
      i_Send = 1'b1;
      tick();
      i_Send = 1'b0;
      rx_frame("neg", 56'hA5_FF_FF_FF_FF_FF_FF, -1, -1, 100, 40'h0, 1'b0);
      frame_end("neg");
      tick();

      // Requests while busy at frame cycles 10 and 200 are ignored.
      d0 = done_cnt;
      i_Data = 40'h01_2345_6789;
      i_Send = 1'b1;
      tick();
      i_Send = 1'b0;
      rx_frame("busyreq", 56'hA5_01_23_45_67_89_89, 10, 200, 10, 40'hAA_AAAA_AAAA, 1'b0);
      frame_end("busyreq");
      saw_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (o_Busy !== 1'b0 || o_Uart_Tx !== 1'b1) saw_busy = 1'b1;
      end
      chk("busyreq_no_second", 64'(saw_busy), 64'd0);
      chk("busyreq_done_cnt",  64'(done_cnt - d0), 64'd1);

      // Held request: two frames, one idle-high cycle between them.
      d0 = done_cnt;
      i_Data = 40'hDE_ADBE_EF01;
      i_Send = 1'b1;
      tick();
      rx_frame("held1", 56'hA5_DE_AD_BE_EF_01_23, -1, -1, -1, '0, 1'b1);
      frame_end("held1");
      rx_frame("held2", 56'hA5_DE_AD_BE_EF_01_23, -1, -1, -1, '0, 1'b0);
      frame_end("held2");
      tick();
      tick();
      chk("held_done_cnt", 64'(done_cnt - d0), 64'd2);
      chk("held_idle",     64'(o_Busy), 64'd0);

      // Reset during the start bit of the third data byte.
      d0 = done_cnt;
      i_Data = 40'h12_3456_789A;
      i_Send = 1'b1;
      tick();
      i_Send = 1'b0;
      repeat (122) tick();
      chk("mid_pre_tx",   64'(o_Uart_Tx), 64'd0);
      chk("mid_pre_busy", 64'(o_Busy),    64'd1);
      #3;
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_tx",   64'(o_Uart_Tx), 64'd1);
      chk("mid_rst_busy", 64'(o_Busy),    64'd0);
      chk("mid_rst_done", 64'(o_Done),    64'd0);
      repeat (2) tick();
      i_rst_n = 1'b1;
      saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_Busy !== 1'b0 || o_Uart_Tx !== 1'b1 || o_Done !== 1'b0) saw_busy = 1'b1;
      end
      chk("mid_abandoned",     64'(saw_busy), 64'd0);
      chk("mid_done_cnt",      64'(done_cnt - d0), 64'd0);
      i_Send = 1'b1;
      tick();
      i_Send = 1'b0;
      rx_frame("after_rst", 56'hA5_12_34_56_78_9A_92, -1, -1, -1, '0, 1'b0);
      frame_end("after_rst");
      tick();
      chk("after_rst_done_cnt", 64'(done_cnt - d0), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
